// File: rtl/if_trace_fifo_pkg.sv
// Defaults and elaboration helpers for the IF trace FIFO.
package if_trace_fifo_pkg;

    localparam int unsigned DEFAULT_DEPTH          = 8;
    localparam int unsigned DEFAULT_DROP_CNT_WIDTH = 16;

    // Storage depth must be a power of two so the pointers wrap on their own.
    function automatic bit depth_is_legal(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/ryuki_datatypes.sv
// Shared datatypes of the ryuki core: the IF tracker's trace record layout.
package ryuki_datatypes;

    // One IF trace record as produced by the IF tracker.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } trace_output;

endpackage

// File: rtl/if_trace_fifo_stats.sv
// Trace stream statistics: sticky overflow flag, saturating drop counter
// and occupancy high-water mark. Kept apart so other trace FIFOs can reuse it.
module if_trace_fifo_stats #(
    parameter int unsigned CNT_W          = 4,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      drop_i,
    input  logic [CNT_W-1:0]          count_next_i,
    input  logic                      clr_i,
    output logic                      overflow_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_count_o,
    output logic [CNT_W-1:0]          high_water_o
);

    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic [CNT_W-1:0]          high_water_q, high_water_d;

    // Next-state statistics; a drop in the clearing cycle survives the clear.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        overflow_d   = overflow_q | drop_i;
        drop_count_d = drop_count_q;
        high_water_d = (count_next_i > high_water_q) ? count_next_i : high_water_q;
        if (drop_i && !(&drop_count_q)) begin
            drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
        end
        if (clr_i) begin
            overflow_d   = drop_i;
            drop_count_d = drop_i ? DROP_CNT_WIDTH'(1) : '0;
            high_water_d = count_next_i;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            high_water_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            high_water_q <= high_water_d;
        end
    end

    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;
    assign high_water_o = high_water_q;

endmodule

// File: rtl/if_trace_fifo.sv
// Circular buffer capturing IF trace records and presenting them
// first-word-fall-through on a ready/valid stream, with drop statistics.
module if_trace_fifo
    import ryuki_datatypes::*;
    import if_trace_fifo_pkg::*;
#(
    parameter int unsigned DEPTH          = DEFAULT_DEPTH,
    parameter int unsigned DROP_CNT_WIDTH = DEFAULT_DROP_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_data_valid,
    input  trace_output                  if_data_i,
    output logic                         out_valid,
    output trace_output                  out_data,
    input  logic                         out_ready,
    input  logic                         flush,
    input  logic                         clr_stats,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow,
    output logic [DROP_CNT_WIDTH-1:0]    drop_count,
    output logic [$clog2(DEPTH+1)-1:0]   high_water
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (!depth_is_legal(DEPTH)) begin : g_depth_check
        $error("if_trace_fifo: DEPTH must be a power of two and at least 2");
    end

    trace_output      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop, push, drop, wr_en, drop_ev;

    // Handshake decode and pointer/occupancy next state; flush overrides everything.
    always_comb begin
        pop      = (count_q != '0) && out_ready;
        push     = if_data_valid && ((count_q != FULL_CNT) || pop);
        drop     = if_data_valid && (count_q == FULL_CNT) && !pop;
        wr_en    = push && !flush;
        drop_ev  = drop && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage write port.
    // NOTE: storage has no reset; out_data is gated by out_valid so stale contents never leak.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= if_data_i;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign full      = (count_q == FULL_CNT);

    if_trace_fifo_stats #(
        .CNT_W          (CNT_W),
        .DROP_CNT_WIDTH (DROP_CNT_WIDTH)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .drop_i       (drop_ev),
        .count_next_i (count_d),
        .clr_i        (clr_stats),
        .overflow_o   (overflow),
        .drop_count_o (drop_count),
        .high_water_o (high_water)
    );

endmodule
